// File: rtl/fir_stream_if.sv
// Stream bundle for fir_stream_filter: input samples, output samples
// and parity-error status.
interface fir_stream_if #(
    parameter int DATA_W    = 16,
    parameter int ERR_CNT_W = 8
);
    logic [DATA_W-1:0]    x_data;
    logic                 x_valid;
    logic                 x_parity;
    logic                 x_ready;
    logic [DATA_W-1:0]    y_data;
    logic                 y_valid;
    logic                 y_parity;
    logic                 y_ready;
    logic                 par_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output x_data, x_valid, x_parity, y_ready,
        input  x_ready, y_data, y_valid, y_parity, par_err, err_cnt
    );

    modport slave (
        input  x_data, x_valid, x_parity, y_ready,
        output x_ready, y_data, y_valid, y_parity, par_err, err_cnt
    );
endinterface

// File: rtl/fir_stream_filter.sv
// Two-stage pipelined N-tap FIR with valid/ready handshakes, bypass,
// synchronous clear and input parity checking.
module fir_stream_filter #(
    parameter int DATA_W    = 16,
    parameter int N_TAPS    = 4,
    parameter int COEF_W    = 8,
    parameter logic [N_TAPS*COEF_W-1:0] COEFS = {N_TAPS{COEF_W'(1)}},
    parameter int SHIFT     = 0,
    parameter int ERR_CNT_W = 8
) (
    input logic         clk,
    input logic         rst,
    input logic         clear,
    input logic         bypass,
    fir_stream_if.slave s
);
    localparam int GUARD  = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + GUARD;

    logic signed [DATA_W-1:0] d_q    [N_TAPS];
    logic signed [DATA_W-1:0] d_next [N_TAPS];
    logic signed [PROD_W-1:0] p_q    [N_TAPS];
    logic signed [PROD_W-1:0] p_d    [N_TAPS];
    logic signed [COEF_W-1:0] coef   [N_TAPS];

    logic                 s1_valid_q;
    logic                 y_valid_q;
    logic                 y_parity_q;
    logic [DATA_W-1:0]    y_data_q;
    logic                 par_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    logic                     en;
    logic                     xfer;
    logic                     bad;
    logic signed [DATA_W-1:0] sample;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sh;
    logic [ACC_W-DATA_W:0]    hi;
    logic [DATA_W-1:0]        sat;
    logic [DATA_W-1:0]        y_d;

    for (genvar k = 0; k < N_TAPS; k++) begin : g_coef
        assign coef[k] = COEFS[k*COEF_W +: COEF_W];
    end

    assign en        = !y_valid_q || s.y_ready;
    assign s.x_ready = en && !clear && rst;
    assign xfer      = s.x_valid && s.x_ready;
    assign bad       = s.x_parity != ^s.x_data;
    assign sample    = bad ? '0 : $signed(s.x_data);

    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            d_next[k] = d_q[k];
        end
        if (xfer) begin
            d_next[0] = sample;
            for (int k = 1; k < N_TAPS; k++) begin
                d_next[k] = d_q[k-1];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < N_TAPS; k++) begin
            p_d[k] = $signed({{COEF_W{d_next[k][DATA_W-1]}}, d_next[k]})
                   * $signed({{DATA_W{coef[k][COEF_W-1]}}, coef[k]});
        end
    end

    // Saturate when the bits above the output sign are not all sign copies.
    always_comb begin
        acc = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            acc = acc + $signed({{GUARD{p_q[k][PROD_W-1]}}, p_q[k]});
        end
        acc_sh = acc >>> SHIFT;
        hi     = acc_sh[ACC_W-1:DATA_W-1];
        if ((&hi) || !(|hi)) begin
            sat = acc_sh[DATA_W-1:0];
        end else if (acc_sh[ACC_W-1]) begin
            sat = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            sat = {1'b0, {(DATA_W-1){1'b1}}};
        end
        y_d = bypass ? d_q[0] : sat;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d_q[k] <= '0;
                p_q[k] <= '0;
            end
            s1_valid_q <= 1'b0;
            y_valid_q  <= 1'b0;
            y_data_q   <= '0;
            y_parity_q <= 1'b0;
            par_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else if (clear) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d_q[k] <= '0;
                p_q[k] <= '0;
            end
            s1_valid_q <= 1'b0;
            y_valid_q  <= 1'b0;
            par_err_q  <= 1'b0;
            err_cnt_q  <= '0;
        end else if (en) begin
            for (int k = 0; k < N_TAPS; k++) begin
                d_q[k] <= d_next[k];
                p_q[k] <= p_d[k];
            end
            s1_valid_q <= xfer;
            y_valid_q  <= s1_valid_q;
            y_data_q   <= y_d;
            y_parity_q <= ^y_d;
            if (xfer && bad) begin
                par_err_q <= 1'b1;
                if (err_cnt_q != '1) begin
                    err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
                end
            end
        end
    end

    assign s.y_data   = y_data_q;
    assign s.y_valid  = y_valid_q;
    assign s.y_parity = y_parity_q;
    assign s.par_err  = par_err_q;
    assign s.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_fir_stream_filter.sv
// Bench for fir_stream_filter: three coefficient sets driven by one stream,
// checked against a queue-based arithmetic model of the filter.
module tb_fir_stream_filter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clear;
    logic        bypass;
    logic        x_valid;
    logic        x_parity;
    logic        y_ready;
    logic [15:0] x_data;

    int tests = 0;
    int fails = 0;

    fir_stream_if #(.DATA_W(16), .ERR_CNT_W(8)) if0 (), if1 (), if2 ();

    assign if0.x_data = x_data;
    assign if0.x_valid = x_valid;
    assign if0.x_parity = x_parity;
    assign if0.y_ready = y_ready;
    assign if1.x_data = x_data;
    assign if1.x_valid = x_valid;
    assign if1.x_parity = x_parity;
    assign if1.y_ready = y_ready;
    assign if2.x_data = x_data;
    assign if2.x_valid = x_valid;
    assign if2.x_parity = x_parity;
    assign if2.y_ready = y_ready;

    fir_stream_filter #(
        .DATA_W(16), .N_TAPS(4), .COEF_W(8),
        .COEFS({4{8'sd1}}), .SHIFT(0), .ERR_CNT_W(8)
    ) u0 (
        .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .s(if0)
    );

    fir_stream_filter #(
        .DATA_W(16), .N_TAPS(4), .COEF_W(8),
        .COEFS({8'sd1, 8'sd2, 8'sd2, 8'sd1}), .SHIFT(1), .ERR_CNT_W(8)
    ) u1 (
        .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .s(if1)
    );

    fir_stream_filter #(
        .DATA_W(16), .N_TAPS(4), .COEF_W(8),
        .COEFS({4{8'sd127}}), .SHIFT(0), .ERR_CNT_W(8)
    ) u2 (
        .clk(clk), .rst(rst), .clear(clear), .bypass(bypass), .s(if2)
    );

    typedef struct packed {
        logic [2:0][15:0] fir;
        logic [15:0]      raw;
    } exp_t;

    typedef struct packed {
        logic [2:0][15:0] got;
        logic [2:0][15:0] want;
    } pair_t;

    int    hist [4];
    int    ccoef [3][4] = '{'{1, 1, 1, 1}, '{1, 2, 2, 1}, '{127, 127, 127, 127}};
    int    cshift [3] = '{0, 1, 0};
    exp_t  exp_q [$];
    pair_t pair_q [$];
    int    extra;
    int    model_err;

    function automatic logic [15:0] model_fir(int c);
        longint sum = 0;
        for (int k = 0; k < 4; k++) sum += longint'(hist[k]) * ccoef[c][k];
        sum = sum >>> cshift[c];
        if (sum > 32767) sum = 32767;
        if (sum < -32768) sum = -32768;
        return 16'(sum);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) hist[k] = 0;
        exp_q.delete();
        pair_q.delete();
        extra = 0;
        model_err = 0;
    endtask

    // One clock: observe handshakes just before the edge, advance the model.
    task automatic tick();
        exp_t  e;
        pair_t p;
        logic  in_x;
        logic  out_x;
        int    smp;
        #1;
        in_x  = x_valid & if0.x_ready;
        out_x = if0.y_valid & y_ready;
        if (out_x) begin
            if (exp_q.size() == 0) extra++;
            else begin
                e = exp_q.pop_front();
                p.got = {if2.y_data, if1.y_data, if0.y_data};
                for (int c = 0; c < 3; c++) p.want[c] = bypass ? e.raw : e.fir[c];
                pair_q.push_back(p);
            end
        end
        if (clear) begin
            for (int k = 0; k < 4; k++) hist[k] = 0;
            exp_q.delete();
            model_err = 0;
        end
        if (in_x) begin
            smp = (x_parity != ^x_data) ? 0 : int'($signed(x_data));
            if (x_parity != ^x_data) model_err++;
            for (int k = 3; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = smp;
            e.raw = 16'(smp);
            for (int c = 0; c < 3; c++) e.fir[c] = model_fir(c);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] v, input logic bad_par);
        x_data   = v;
        x_parity = (^v) ^ bad_par;
        x_valid  = 1'b1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        clear = 1'b0;
        bypass = 1'b0;
        x_valid = 1'b0;
        x_data = '0;
        x_parity = 1'b0;
        y_ready = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic drain();
        x_valid = 1'b0;
        y_ready = 1'b1;
        repeat (6) tick();
    endtask

    task automatic test_reset();
        reset_dut();
        send(16'h1234, 1'b1);
        rst = 1'b0;
        #1;
        tests++;
        if (if0.x_ready !== 1'b0) begin
            fails++; $display("FAIL reset_x_ready got %b want 0", if0.x_ready);
        end
        tests++;
        if ({if0.y_valid, if1.y_valid, if2.y_valid} !== 3'b000) begin
            fails++; $display("FAIL reset_y_valid got %b want 000",
                {if0.y_valid, if1.y_valid, if2.y_valid});
        end
        tests++;
        if (if0.y_data !== 16'h0 || if0.y_parity !== 1'b0) begin
            fails++; $display("FAIL reset_y_data got %h/%b want 0/0", if0.y_data, if0.y_parity);
        end
        tests++;
        if (if0.par_err !== 1'b0 || if0.err_cnt !== 8'd0) begin
            fails++; $display("FAIL reset_err got %b/%0d want 0/0", if0.par_err, if0.err_cnt);
        end
        x_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_stream();
        logic [15:0] want [5] = '{16'd3, 16'd6, 16'd9, 16'd12, 16'd12};
        pair_t p;
        reset_dut();
        send(16'd3, 1'b0);
        tick();
        tests++;
        if (if0.y_valid !== 1'b0) begin
            fails++; $display("FAIL stream_lat1 got y_valid %b want 0", if0.y_valid);
        end
        tick();
        tests++;
        if (if0.y_valid !== 1'b1) begin
            fails++; $display("FAIL stream_lat2 got y_valid %b want 1", if0.y_valid);
        end
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (if0.y_data !== want[i] || if0.y_parity !== ^want[i]) begin
                fails++; $display("FAIL stream_seq%0d got %0d/%b want %0d/%b",
                    i, if0.y_data, if0.y_parity, want[i], ^want[i]);
            end
            tick();
        end
        drain();
        while (pair_q.size() > 0) begin
            p = pair_q.pop_front();
            tests++;
            if (p.got !== p.want) begin
                fails++; $display("FAIL stream_sb got %h want %h", p.got, p.want);
            end
        end
        tests++;
        if (extra !== 0) begin
            fails++; $display("FAIL stream_extra got %0d want 0", extra);
        end
    endtask

    task automatic test_stall();
        bit    found = 0;
        pair_t p;
        reset_dut();
        send(16'd3, 1'b0);
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (if0.y_valid === 1'b1 && if0.y_data === 16'd6) found = 1;
        end
        tests++;
        if (!found) begin
            fails++; $display("FAIL stall_wait got no y_data 6 want 6 within 10 cycles");
        end
        y_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (if0.y_data !== 16'd6 || if0.y_valid !== 1'b1 || if0.x_ready !== 1'b0) begin
                fails++; $display("FAIL stall_hold%0d got %0d/%b/%b want 6/1/0",
                    i, if0.y_data, if0.y_valid, if0.x_ready);
            end
        end
        y_ready = 1'b1;
        tick();
        tests++;
        if (if0.y_data !== 16'd9) begin
            fails++; $display("FAIL stall_after1 got %0d want 9", if0.y_data);
        end
        tick();
        tests++;
        if (if0.y_data !== 16'd12) begin
            fails++; $display("FAIL stall_after2 got %0d want 12", if0.y_data);
        end
        drain();
        while (pair_q.size() > 0) begin
            p = pair_q.pop_front();
            tests++;
            if (p.got !== p.want) begin
                fails++; $display("FAIL stall_sb got %h want %h", p.got, p.want);
            end
        end
    endtask

    task automatic test_parity();
        logic [15:0] got [$];
        logic [15:0] want [4] = '{16'd0, 16'd3, 16'd6, 16'd9};
        reset_dut();
        send(16'd3, 1'b1);
        tick();
        send(16'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            if (if0.y_valid === 1'b1) got.push_back(if0.y_data);
        end
        x_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (if0.y_valid === 1'b1) got.push_back(if0.y_data);
        end
        tests++;
        if (got.size() != 4) begin
            fails++; $display("FAIL parity_count got %0d want 4", got.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (got[i] !== want[i]) begin
                    fails++; $display("FAIL parity_seq%0d got %0d want %0d", i, got[i], want[i]);
                end
            end
        end
        tests++;
        if (if0.par_err !== 1'b1 || if0.err_cnt !== 8'd1) begin
            fails++; $display("FAIL parity_flag got %b/%0d want 1/1", if0.par_err, if0.err_cnt);
        end
        for (int i = 0; i < 258; i++) begin
            send(16'($urandom), 1'b1);
            tick();
        end
        tests++;
        if (if0.err_cnt !== 8'd255 || if2.par_err !== 1'b1) begin
            fails++; $display("FAIL parity_sat got %0d/%b want 255/1", if0.err_cnt, if2.par_err);
        end
        drain();
    endtask

    task automatic test_coefs();
        logic [15:0] q1 [$];
        logic [15:0] q2 [$];
        logic [15:0] want [4] = '{16'd16383, 16'd32767, 16'd32767, 16'd16383};
        bit found = 0;
        reset_dut();
        send(16'h7FFF, 1'b0);
        tick();
        send(16'h0000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (if1.y_valid === 1'b1) begin
                q1.push_back(if1.y_data);
                q2.push_back(if2.y_data);
            end
        end
        tests++;
        if (q1.size() < 5) begin
            fails++; $display("FAIL coef_count got %0d want >=5", q1.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests++;
                if (q1[i] !== want[i]) begin
                    fails++; $display("FAIL coef_seq%0d got %0d want %0d", i, q1[i], want[i]);
                end
            end
            tests++;
            if (q1[4] !== 16'd0) begin
                fails++; $display("FAIL coef_tail got %0d want 0", q1[4]);
            end
            tests++;
            if (q2[0] !== 16'h7FFF) begin
                fails++; $display("FAIL sat_pos got %h want 7fff", q2[0]);
            end
        end
        reset_dut();
        send(16'h8000, 1'b0);
        tick();
        x_valid = 1'b0;
        for (int i = 0; i < 6 && !found; i++) begin
            tick();
            if (if2.y_valid === 1'b1) found = 1;
        end
        tests++;
        if (!found || if2.y_data !== 16'h8000 || if1.y_data !== 16'hC000) begin
            fails++; $display("FAIL sat_neg got %h/%h want 8000/c000", if2.y_data, if1.y_data);
        end
        drain();
    endtask

    task automatic test_bypass();
        reset_dut();
        bypass = 1'b1;
        send(16'd5, 1'b0);
        tick();
        send(16'd7, 1'b0);
        tick();
        x_valid = 1'b0;
        tests++;
        if (if0.y_valid !== 1'b1 || if0.y_data !== 16'd5 || if2.y_data !== 16'd5) begin
            fails++; $display("FAIL bypass_first got %b/%0d/%0d want 1/5/5",
                if0.y_valid, if0.y_data, if2.y_data);
        end
        tick();
        tests++;
        if (if0.y_valid !== 1'b1 || if1.y_data !== 16'd7 || if2.y_data !== 16'd7) begin
            fails++; $display("FAIL bypass_second got %b/%0d/%0d want 1/7/7",
                if0.y_valid, if1.y_data, if2.y_data);
        end
        drain();
        bypass = 1'b0;
    endtask

    task automatic test_clear();
        logic [15:0] held;
        pair_t p;
        reset_dut();
        send(16'd3, 1'b1);
        tick();
        send(16'd3, 1'b0);
        repeat (3) tick();
        held = if0.y_data;
        clear = 1'b1;
        #1;
        tests++;
        if (if0.x_ready !== 1'b0) begin
            fails++; $display("FAIL clear_x_ready got %b want 0", if0.x_ready);
        end
        tick();
        clear = 1'b0;
        tests++;
        if (if0.y_valid !== 1'b0 || if0.par_err !== 1'b0 || if0.err_cnt !== 8'd0) begin
            fails++; $display("FAIL clear_state got %b/%b/%0d want 0/0/0",
                if0.y_valid, if0.par_err, if0.err_cnt);
        end
        tests++;
        if (if0.y_data !== held || if0.y_parity !== ^held) begin
            fails++; $display("FAIL clear_hold got %0d want %0d", if0.y_data, held);
        end
        send(16'd4, 1'b0);
        tick();
        x_valid = 1'b0;
        tick();
        tests++;
        if (if0.y_valid !== 1'b1 || if0.y_data !== 16'd4 || if1.y_data !== 16'd2 ||
            if2.y_data !== 16'd508) begin
            fails++; $display("FAIL clear_hist got %b/%0d/%0d/%0d want 1/4/2/508",
                if0.y_valid, if0.y_data, if1.y_data, if2.y_data);
        end
        drain();
        while (pair_q.size() > 0) begin
            p = pair_q.pop_front();
            tests++;
            if (p.got !== p.want) begin
                fails++; $display("FAIL clear_sb got %h want %h", p.got, p.want);
            end
        end
    endtask

    task automatic test_async_reset();
        reset_dut();
        send(16'd3, 1'b1);
        tick();
        send(16'd3, 1'b0);
        repeat (4) tick();
        #2;
        rst = 1'b0;
        x_valid = 1'b0;
        #1;
        tests++;
        if (if0.y_valid !== 1'b0 || if0.y_data !== 16'd0 || if1.y_data !== 16'd0) begin
            fails++; $display("FAIL arst_out got %b/%0d/%0d want 0/0/0",
                if0.y_valid, if0.y_data, if1.y_data);
        end
        tests++;
        if (if0.par_err !== 1'b0 || if0.err_cnt !== 8'd0 || if0.x_ready !== 1'b0) begin
            fails++; $display("FAIL arst_err got %b/%0d/%b want 0/0/0",
                if0.par_err, if0.err_cnt, if0.x_ready);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        send(16'd5, 1'b0);
        tick();
        x_valid = 1'b0;
        tick();
        tests++;
        if (if0.y_valid !== 1'b1 || if0.y_data !== 16'd5 || if1.y_data !== 16'd2 ||
            if2.y_data !== 16'd635) begin
            fails++; $display("FAIL arst_first got %b/%0d/%0d/%0d want 1/5/2/635",
                if0.y_valid, if0.y_data, if1.y_data, if2.y_data);
        end
        drain();
    endtask

    task automatic test_random();
        pair_t p;
        int    v;
        int    want_cnt;
        reset_dut();
        for (int ph = 0; ph < 2; ph++) begin
            bypass = ph[0];
            for (int i = 0; i < 300; i++) begin
                v = $urandom_range(0, 9);
                send((v == 0) ? 16'h7FFF : (v == 1) ? 16'h8000 : 16'($urandom),
                     $urandom_range(0, 19) == 0);
                x_valid = $urandom_range(0, 9) < 7;
                y_ready = $urandom_range(0, 9) < 7;
                tick();
            end
            drain();
        end
        bypass = 1'b0;
        tests++;
        if (pair_q.size() < 100) begin
            fails++; $display("FAIL rand_count got %0d want >=100", pair_q.size());
        end
        while (pair_q.size() > 0) begin
            p = pair_q.pop_front();
            for (int c = 0; c < 3; c++) begin
                tests++;
                if (p.got[c] !== p.want[c]) begin
                    fails++; $display("FAIL rand_inst%0d got %h want %h", c, p.got[c], p.want[c]);
                end
            end
        end
        tests++;
        if (exp_q.size() != 0 || extra != 0) begin
            fails++; $display("FAIL rand_leftover got %0d/%0d want 0/0", exp_q.size(), extra);
        end
        want_cnt = (model_err > 255) ? 255 : model_err;
        tests++;
        if (if0.err_cnt !== 8'(want_cnt) || if0.par_err !== (model_err > 0)) begin
            fails++; $display("FAIL rand_err got %0d/%b want %0d/%b",
                if0.err_cnt, if0.par_err, want_cnt, model_err > 0);
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        clear = 1'b0;
        bypass = 1'b0;
        x_valid = 1'b0;
        x_data = '0;
        x_parity = 1'b0;
        y_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_stream();
        test_stall();
        test_parity();
        test_coefs();
        test_bypass();
        test_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/fir_stream_filter.md
Name: fir_stream_filter

Overview:
- Parametrised successor to the fixed single-channel filter block: an N-tap FIR over signed samples, with a programmable coefficient set.
- Carries valid/ready handshakes on both sides and provides input parity checking with even-parity output generation.
- Adds a bypass mode, a synchronous clear, and parity-error reporting.
- Sits between the sample source and downstream consumers in the streaming datapath.

Parameters:
- DATA_W, 16, sample width (signed two's complement) for x_data and y_data.
- N_TAPS, 4, number of taps; allowed range 1..16.
- COEF_W, 8, width of each signed coefficient.
- COEFS, {4{8'sd1}}, packed N_TAPS*COEF_W vector; tap k is bits [k*COEF_W +: COEF_W].
- SHIFT, 0, arithmetic right shift applied to the accumulator before saturation.
- ERR_CNT_W, 8, width of the parity-error counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- clear  in  1  synchronous clear of the delay line, pipeline valids and error state.
- bypass  in  1  1 = y is the delayed input sample; 0 = FIR result.
- x_data  in  DATA_W  input sample.
- x_valid  in  1  input sample valid.
- x_parity  in  1  even parity of x_data (^x_data).
- x_ready  out  1  block accepts an input this cycle.
- y_data  out  DATA_W  output sample.
- y_valid  out  1  output valid.
- y_parity  out  1  ^y_data, generated from the registered y_data.
- y_ready  in  1  downstream accepts the output.
- par_err  out  1  sticky flag: at least one parity error since reset or clear.
- err_cnt  out  ERR_CNT_W  count of parity errors, saturating at all-ones.

Behaviour:
- Reset (rst=0, async): delay line = 0; s1_valid = 0; y_valid = 0; y_data = 0; y_parity = 0; par_err = 0; err_cnt = 0. x_ready reads 0 during reset.
- Stall: en = !y_valid | y_ready. x_ready = en & !clear & rst. A transfer occurs on x_valid & x_ready; the output transfer occurs on y_valid & y_ready.
- Delay line d[0..N_TAPS-1]: shifts only on an input transfer, with d[0] <= sample and d[k] <= d[k-1].
- Accepted sample: the sample is x_data. If x_parity != ^x_data, the sample written is 0, par_err is set, and err_cnt increments (saturating).
- Stage 1 (on en): registers products p[k] = d_next[k]*COEF[k] at full precision (DATA_W+COEF_W bits). d_next is the post-shift line. s1_valid <= transfer.
- Stage 2 (on en): acc = sum p[k] in DATA_W+COEF_W+clog2(N_TAPS) bits; acc >>> SHIFT; saturate to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - y_data <= bypass ? registered d[0] : saturated result.
  - y_valid <= s1_valid. y_parity <= ^(value loaded into y_data).
- Latency: y_valid is high 2 cycles after the accepting edge when unstalled. Throughput is 1 sample/cycle.
- Backpressure: when y_valid=1 and y_ready=0, en=0. All registers hold and y_data is stable until accepted.
- Bubbles: no input transfer means s1_valid=0 next cycle; the delay line does not shift.
- clear=1 (sync, overrides everything except rst):
  - Next edge: delay line = 0, s1_valid = 0, y_valid = 0, par_err = 0, err_cnt = 0.
  - The input is not accepted that cycle.
  - y_data/y_parity hold their value.
- bypass: may change at any time. It takes effect at the stage-2 load and is sampled per output; it does not alter the delay-line contents.
- Reset mid-operation: all in-flight samples are discarded. After release, the first output corresponds to the first post-reset accepted sample, with history = 0.

Test Plan:
- Defaults; after reset, hold x_data=3, x_valid=1, x_parity=0, y_ready=1 -> y_valid rises 2 cycles after first accept. y_data sequence 3, 6, 9, 12, 12, and y_parity 0, 0, 0, 0, 0.
- Same stream with y_ready=0 for 3 cycles once y_data=6 -> x_ready=0, y_data held at 6, no sample lost. After release, sequence continues 9, 12.
- Input 3 with x_parity=1 -> par_err=1, err_cnt=1, and that sample contributes 0. With prior history zero: outputs 0, then 3, 6, 9 for following good samples.
- COEFS={1,2,2,1}, SHIFT=1, impulse 16'sh7FFF then zeros -> outputs 16383, 32767, 32767, 16383. Verify the saturation path with COEFS all 8'sd127, input 16'sh7FFF -> 16'sh7FFF, and input 16'sh8000 -> 16'sh8000.
- bypass=1, inputs 5, 7 -> y_data 5, 7 at latency 2. clear pulse mid-stream -> y_valid=0 next cycle, par_err/err_cnt = 0, and the next FIR output uses zeroed history.
- rst pulsed low asynchronously mid-stream (between edges) -> all outputs 0 immediately. After release, the first output equals the first new sample times COEF[0].
